// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg
//   Shared definitions for the CPU boot sequencer: the sequencer state
//   encoding, byte strides of the two external memory ports, the dump FIFO
//   depth, and the phase-skipping helper used at every phase boundary.
`timescale 1ns/1ps
package boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_I = 3'd1,
    ST_LOAD_D = 3'd2,
    ST_RUN    = 3'd3,
    ST_DUMP   = 3'd4
  } state_t;

  // Byte distance between consecutive words on each memory port.
  localparam int unsigned IMEM_STRIDE = 4;
  localparam int unsigned DMEM_STRIDE = 8;

  // Dump output buffer depth.
  localparam int unsigned FIFO_DEPTH = 2;

  // Picks the first phase after 'after' whose word/cycle count is nonzero.
  // The data count gates both LOAD_D and DUMP, so it appears twice in the
  // walk. Returning ST_IDLE means the whole sequence is complete.
  function automatic state_t next_phase(input state_t after,
                                        input logic   imem_nz,
                                        input logic   dmem_nz,
                                        input logic   run_nz);
    state_t nxt;
    nxt = ST_IDLE;
    case (after)
      ST_IDLE: begin
        if (imem_nz)      nxt = ST_LOAD_I;
        else if (dmem_nz) nxt = ST_LOAD_D;
        else if (run_nz)  nxt = ST_RUN;
        else              nxt = ST_IDLE;
      end
      ST_LOAD_I: begin
        if (dmem_nz)      nxt = ST_LOAD_D;
        else if (run_nz)  nxt = ST_RUN;
        else              nxt = ST_IDLE;
      end
      ST_LOAD_D: begin
        if (run_nz)       nxt = ST_RUN;
        else if (dmem_nz) nxt = ST_DUMP;
        else              nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (dmem_nz)      nxt = ST_DUMP;
        else              nxt = ST_IDLE;
      end
      default:            nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/boot_dump_fifo.sv
// boot_dump_fifo
//   Two-entry FIFO that registers the data-memory dump stream so out_data
//   is a flop output and holds steady while the host stalls.
// Ports
//   clk, arst  : clock, asynchronous active-high reset
//   flush      : empties the FIFO (wins over push/pop)
//   push       : write push_data this cycle (caller guarantees not full)
//   push_data  : word to store
//   pop        : drop the head entry this cycle (caller guarantees not empty)
//   pop_data   : current head entry
//   count      : current occupancy, 0..2
`timescale 1ns/1ps
module boot_dump_fifo
  import boot_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_comb begin
      mem_d[gi] = mem_q[gi];
      if (push && !flush && (wr_ptr_q == 1'(gi))) begin
        mem_d[gi] = push_data;
      end
    end

    always_ff @(posedge clk or posedge arst) begin
      if (arst) mem_q[gi] <= '0;
      else      mem_q[gi] <= mem_d[gi];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl
//   Boot sequencer for the pipelined RISC-V core: holds the core in reset,
//   preloads instruction memory (*_ext) and data memory (*_ext_2) from the
//   host stream, enables the core for a programmed number of cycles, then
//   freezes it and streams a span of data memory back to the host.
// Ports
//   clk, arst                    : clock, asynchronous active-high reset
//   start, abort                 : sequence request / return to IDLE
//   cfg_imem_words/dmem/run      : counts latched on start
//   in_valid/in_ready/in_data    : host load stream
//   out_valid/out_ready/out_data : dump stream (registered by 2-entry FIFO)
//   cpu_arst_n, cpu_enable       : core reset (active low) and enable
//   addr_ext/wen_ext/wdata_ext   : instruction memory write port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2 : data memory port
//   busy, done                   : not-IDLE status, completion pulse
`timescale 1ns/1ps
module cpu_boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int IMEM_CNT_W = 10,
  parameter int DMEM_CNT_W = 11,
  parameter int RUN_W      = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IMEM_CNT_W-1:0] cfg_imem_words,
  input  logic [DMEM_CNT_W-1:0] cfg_dmem_words,
  input  logic [RUN_W-1:0]      cfg_run_cycles,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_data,
  output logic                  cpu_arst_n,
  output logic                  cpu_enable,
  output logic [63:0]           addr_ext,
  output logic                  wen_ext,
  output logic [31:0]           wdata_ext,
  output logic [63:0]           addr_ext_2,
  output logic                  wen_ext_2,
  output logic                  ren_ext_2,
  output logic [63:0]           wdata_ext_2,
  input  logic [63:0]           rdata_ext_2,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (IMEM_CNT_W > DMEM_CNT_W) ? IMEM_CNT_W : DMEM_CNT_W;

  state_t                  state_q, state_d;
  state_t                  nxt_phase;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        idx_inc;
  logic [RUN_W-1:0]        run_cnt_q, run_cnt_d;
  logic [IMEM_CNT_W-1:0]   imem_words_q, imem_words_d;
  logic [DMEM_CNT_W-1:0]   dmem_words_q, dmem_words_d;
  logic [RUN_W-1:0]        run_cycles_q, run_cycles_d;
  logic                    inflight_q, inflight_d;
  logic                    done_q, done_d;

  logic                    beat;
  logic                    fifo_flush;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [63:0]             fifo_head;
  logic [1:0]              fifo_count;
  logic [2:0]              dump_occ;
  logic                    dump_all_issued;

  assign idx_inc         = idx_q + IDX_W'(1);
  assign beat            = in_valid && !abort;
  assign out_valid       = (fifo_count != 2'd0);
  assign out_data        = out_valid ? fifo_head : 64'd0;
  assign fifo_pop        = out_valid && out_ready;
  // A read issued last cycle returns now; capture it into the FIFO.
  assign fifo_push       = inflight_q;
  // Occupancy after this cycle's pop plus the read still returning. Counting
  // the pop lets a new read issue every cycle while the host keeps up.
  assign dump_occ        = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
  assign dump_all_issued = (idx_q == IDX_W'(dmem_words_q));
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;

  always_comb begin
    state_d      = state_q;
    nxt_phase    = ST_IDLE;
    idx_d        = idx_q;
    run_cnt_d    = run_cnt_q;
    imem_words_d = imem_words_q;
    dmem_words_d = dmem_words_q;
    run_cycles_d = run_cycles_q;
    inflight_d   = 1'b0;
    done_d       = 1'b0;
    fifo_flush   = 1'b0;
    in_ready     = 1'b0;
    wen_ext      = 1'b0;
    addr_ext     = 64'd0;
    wdata_ext    = 32'd0;
    wen_ext_2    = 1'b0;
    ren_ext_2    = 1'b0;
    addr_ext_2   = 64'd0;
    wdata_ext_2  = 64'd0;
    cpu_arst_n   = 1'b0;
    cpu_enable   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          imem_words_d = cfg_imem_words;
          dmem_words_d = cfg_dmem_words;
          run_cycles_d = cfg_run_cycles;
          run_cnt_d    = cfg_run_cycles;
          idx_d        = '0;
          // Live cfg values here: the latched copies update only next cycle.
          nxt_phase = next_phase(ST_IDLE, |cfg_imem_words, |cfg_dmem_words,
                                 |cfg_run_cycles);
          state_d   = nxt_phase;
          done_d    = (nxt_phase == ST_IDLE);
        end
      end

      ST_LOAD_I: begin
        in_ready = !abort;
        if (beat) begin
          wen_ext   = 1'b1;
          wdata_ext = in_data[31:0];
          addr_ext  = 64'(idx_q) * 64'(IMEM_STRIDE);
          idx_d     = idx_inc;
          if (idx_inc == IDX_W'(imem_words_q)) begin
            nxt_phase = next_phase(ST_LOAD_I, 1'b1, |dmem_words_q,
                                   |run_cycles_q);
            state_d   = nxt_phase;
            idx_d     = '0;
            done_d    = (nxt_phase == ST_IDLE);
          end
        end
      end

      ST_LOAD_D: begin
        in_ready = !abort;
        if (beat) begin
          wen_ext_2   = 1'b1;
          wdata_ext_2 = in_data;
          addr_ext_2  = 64'(idx_q) * 64'(DMEM_STRIDE);
          idx_d       = idx_inc;
          if (idx_inc == IDX_W'(dmem_words_q)) begin
            nxt_phase = next_phase(ST_LOAD_D, 1'b0, 1'b1, |run_cycles_q);
            state_d   = nxt_phase;
            idx_d     = '0;
            done_d    = (nxt_phase == ST_IDLE);
          end
        end
      end

      ST_RUN: begin
        cpu_arst_n = 1'b1;
        cpu_enable = 1'b1;
        // Entered only with a nonzero count, so the last cycle is at 1.
        if (run_cnt_q == RUN_W'(1)) begin
          nxt_phase = next_phase(ST_RUN, 1'b0, |dmem_words_q, 1'b0);
          state_d   = nxt_phase;
          idx_d     = '0;
          done_d    = (nxt_phase == ST_IDLE);
        end else begin
          run_cnt_d = run_cnt_q - RUN_W'(1);
        end
      end

      ST_DUMP: begin
        // Core stays out of reset with enable low so its state is frozen.
        cpu_arst_n = 1'b1;
        if (!abort && !dump_all_issued && (dump_occ < 3'd2)) begin
          ren_ext_2  = 1'b1;
          addr_ext_2 = 64'(idx_q) * 64'(DMEM_STRIDE);
          idx_d      = idx_inc;
          inflight_d = 1'b1;
        end
        if (fifo_pop && (fifo_count == 2'd1) && !inflight_q && dump_all_issued) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
      fifo_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      run_cnt_q    <= '0;
      imem_words_q <= '0;
      dmem_words_q <= '0;
      run_cycles_q <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_cnt_q    <= run_cnt_d;
      imem_words_q <= imem_words_d;
      dmem_words_q <= dmem_words_d;
      run_cycles_q <= run_cycles_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
    end
  end

  boot_dump_fifo #(
    .DATA_W(64)
  ) u_dump_fifo (
    .clk      (clk),
    .arst     (arst),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data(rdata_ext_2),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .count    (fifo_count)
  );

endmodule
